// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: default widths, the bubble instruction and FSM state encoding.
package riscv_pkg;

    localparam int unsigned DEF_PC_W  = 9;
    localparam int unsigned DEF_INS_W = 32;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t REQ  = 1'b0;
    localparam fetch_state_t WAIT = 1'b1;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} holding buffer used while decode is stalled on a full IF/ID register.
module fetch_skid #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic             clear_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [INS_W-1:0] instr_i,
    output logic             full_o,
    output logic [PC_W-1:0]  pc_o,
    output logic [INS_W-1:0] instr_o
);

    logic             full_q, full_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [INS_W-1:0] instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i || drain_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time and fills IF/ID,
// absorbing decode stalls through a skid entry and redirects through a stale-response kill.
module fetch_unit #(
    parameter int unsigned       PC_W      = riscv_pkg::DEF_PC_W,
    parameter int unsigned       INS_W     = riscv_pkg::DEF_INS_W,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [INS_W-1:0]  NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             imem_valid,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             ifid_valid,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [INS_W-1:0] ifid_instr
);

    import riscv_pkg::*;

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             kill_q, kill_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [INS_W-1:0] ifid_instr_q, ifid_instr_d;

    logic             skid_full, skid_load, skid_drain, skid_clear;
    logic [PC_W-1:0]  skid_pc;
    logic [INS_W-1:0] skid_instr;
    logic             resp_live;
    logic             unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    fetch_skid #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) u_skid (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    // No request while a stale response is still owed, so only one can ever be outstanding.
    assign imem_req  = (state_q == REQ) && !reset && !redirect && !skid_full && !kill_q;
    assign imem_addr = pc_q;
    assign resp_live = imem_valid && (state_q == WAIT) && !kill_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;
        skid_clear   = 1'b0;

        if (redirect) begin
            pc_d         = {redirect_pc[PC_W-1:2], 2'b00};
            state_d      = REQ;
            // A response arriving in this very cycle is the outstanding one; drop it here.
            kill_d       = ((state_q == WAIT) || kill_q) && !imem_valid;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_clear   = 1'b1;
        end else begin
            if (kill_q && imem_valid) begin
                kill_d = 1'b0;
            end
            if (imem_req) begin
                state_d = WAIT;
            end

            if (resp_live) begin
                state_d = REQ;
                pc_d    = pc_q + PC_W'(4);
                if (!ifid_valid_q || !stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_rdata;
                end else begin
                    skid_load = 1'b1;
                end
            end else if (skid_full && !stall) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = skid_pc;
                ifid_instr_d = skid_instr;
                skid_drain   = 1'b1;
            end else if (!stall) begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;

    a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
        !(imem_valid && (state_q == REQ) && !kill_q))
        else $error("imem_valid without an outstanding request");

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage with IF/ID pipeline register, directly upstream of the decode controller. It owns the PC and issues one request at a time to a variable-latency instruction memory. Returned words are captured into the IF/ID register, where ifid_instr[6:0] drives the controller's Opcode input. Decode stalls and branch/jump redirects are absorbed through a 1-entry skid buffer and a kill mechanism for in-flight requests.

Parameters:
PC_W, 9, PC/instruction-address width in bits (byte address)
INS_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) placed in IF/ID on reset/flush

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  request pulse, 1 cycle per fetch
imem_addr  out  PC_W  fetch address, equals current PC
imem_rdata  in  INS_W  returned instruction, qualified by imem_valid
imem_valid  in  1  exactly one pulse per accepted req, latency >= 1 cycle
stall  in  1  decode not ready: hold IF/ID contents
redirect  in  1  branch/jump taken: flush and refetch
redirect_pc  in  PC_W  target address; bits [1:0] ignored (forced 00)
ifid_valid  out  1  IF/ID holds a real instruction
ifid_pc  out  PC_W  PC of ifid_instr
ifid_instr  out  INS_W  instruction to decode (NOP_INSTR when invalid)

Behaviour:
- One clock, clk; reset synchronous, active-high. Reset: pc=RESET_PC, state=REQ, kill=0, skid empty, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR. imem_req=0 during the reset cycle.
- FSM states REQ, WAIT.
- REQ: imem_req = !reset && !redirect && !skid_full. When asserted, move to WAIT next cycle. imem_addr=pc is combinational and always valid.
- WAIT: imem_req=0. On imem_valid, go to REQ with pc <= pc+4 (mod 2^PC_W, wraps to 0).
- Best-case throughput is one instruction per 2 cycles with 1-cycle memory latency.
- Response capture, when not killed and not redirecting:
  - If !ifid_valid || !stall: IF/ID <= {1, pc_of_req, imem_rdata}.
  - Otherwise the word goes into the skid buffer {pc, instr}.
- Skid drain: when skid is full and !stall, skid moves to IF/ID in that cycle. A response cannot arrive then, because no request was issued while the skid was full.
- Stall with no new data: IF/ID holds all fields unchanged.
- No stall and no new data: ifid_valid <= 0 and ifid_instr <= NOP_INSTR.
- Redirect has highest priority after reset. In the redirect cycle:
  - pc <= {redirect_pc[PC_W-1:2],2'b00}.
  - ifid_valid <= 0, ifid_instr <= NOP_INSTR, skid emptied.
  - state <= REQ; the first request to the target issues the next cycle.
  - If state==WAIT and imem_valid=0: kill <= 1.
  - If imem_valid=1 in the same cycle: that word is dropped and kill stays 0.
- kill=1: the next imem_valid is discarded (no capture, pc unchanged by it), then kill <= 0. In REQ with kill=1, imem_req is held low until the stale response arrives.
- Redirect overrides stall. Back-to-back redirects: the last one wins, and a single kill covers the one outstanding request.
- Invariant: at most one outstanding request. imem_valid in REQ with kill=0 is a protocol error; assert this in simulation only.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR constant, fetch_state_t enum {REQ, WAIT}, PC_W/INS_W defaults.
- Sub-module fetch_skid (1-entry buffer, load/drain/clear, full flag) is natural. Everything else stays in fetch_unit.

Test Plan:
- Reset then 1-cycle memory returning 0x00500093, 0x00A00113: imem_addr 0 then 4; IF/ID shows pc=0/0x00500093, then pc=4/0x00A00113, ifid_valid pulses.
- stall=1 for 5 cycles while pc=8 and pc=12 return: IF/ID holds pc=8, skid holds pc=12, no imem_req while full; on release, pc=12 is presented next cycle, then fetch of 16 resumes.
- 3-cycle latency, redirect to 0x40 in WAIT: ifid_valid=0 with NOP; stale response dropped; next req addr=0x40; first valid IF/ID pc=0x40.
- redirect and imem_valid in same cycle (redirect_pc=0x23): word dropped, no kill, next req addr=0x20.
- PC wrap: RESET_PC=0x1FC, PC_W=9: fetches 0x1FC then 0x000.
- reset asserted mid-WAIT with skid full: next cycle all outputs at reset values, imem_req=0; the following cycle imem_req=1 with addr=RESET_PC.
